// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: two-requester round-robin owner of a 4-digit display,
// frame-latched data, blank-gapped digit scan.
module seg_scan_arbiter #(
  parameter int DIV          = 1024,
  parameter int BLANK_CYC    = 16,
  parameter int DWELL_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  grant,
  output logic        frame_done,
  output logic [3:0]  drains,
  output logic [7:0]  leds
);

  localparam int SW  = $clog2(DIV);
  localparam int DWW = $clog2(DWELL_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW0,
    SHOW1
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [1:0]      digit_q, digit_d;
  logic [DWW-1:0]  dwell_q, dwell_inc;
  logic            last_q;
  logic [15:0]     shadow_q, shadow_d;
  logic            blank_q, blank_d;
  logic            boundary, dwell_ok;
  logic            lit;
  logic [3:0]      nib;

  function automatic logic [7:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 8'h3F;
      4'h1: hex_font = 8'h06;
      4'h2: hex_font = 8'h5B;
      4'h3: hex_font = 8'h4F;
      4'h4: hex_font = 8'h66;
      4'h5: hex_font = 8'h6D;
      4'h6: hex_font = 8'h7D;
      4'h7: hex_font = 8'h07;
      4'h8: hex_font = 8'h7F;
      4'h9: hex_font = 8'h6F;
      4'hA: hex_font = 8'h77;
      4'hB: hex_font = 8'h7C;
      4'hC: hex_font = 8'h39;
      4'hD: hex_font = 8'h5E;
      4'hE: hex_font = 8'h79;
      default: hex_font = 8'h71;
    endcase
  endfunction

  always_comb begin
    boundary = (slot_q == SW'(DIV - 1)) && (digit_q == 2'd3);
    slot_d   = (slot_q == SW'(DIV - 1)) ? '0 : slot_q + 1'b1;
    digit_d  = (slot_q == SW'(DIV - 1)) ? digit_q + 2'd1 : digit_q;

    // Count the frame now completing, so the hold lasts DWELL_FRAMES frames
    dwell_inc = (dwell_q == DWW'(DWELL_FRAMES)) ? dwell_q
                                                : dwell_q + 1'b1;
    dwell_ok  = (dwell_inc == DWW'(DWELL_FRAMES));

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req == 2'b11)
          state_d = last_q ? SHOW0 : SHOW1;
        else if (req[0])
          state_d = SHOW0;
        else if (req[1])
          state_d = SHOW1;
      end
      SHOW0: begin
        if (!req[0])
          state_d = req[1] ? SHOW1 : IDLE;
        else if (dwell_ok && req[1])
          state_d = SHOW1;
      end
      SHOW1: begin
        if (!req[1])
          state_d = req[0] ? SHOW0 : IDLE;
        else if (dwell_ok && req[0])
          state_d = SHOW0;
      end
      default: state_d = IDLE;
    endcase

    shadow_d = shadow_q;
    blank_d  = blank_q;
    if (boundary) begin
      blank_d  = (state_d == IDLE);
      shadow_d = (state_d == SHOW0) ? data0 :
                 (state_d == SHOW1) ? data1 : 16'h0000;
    end

    nib = shadow_d[{digit_d, 2'b00} +: 4];
    lit = !blank_d && (slot_d >= SW'(BLANK_CYC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      digit_q    <= '0;
      dwell_q    <= '0;
      last_q     <= 1'b1;
      shadow_q   <= '0;
      blank_q    <= 1'b1;
      grant      <= '0;
      frame_done <= 1'b0;
      drains     <= '0;
      leds       <= '0;
    end else begin
      slot_q     <= slot_d;
      digit_q    <= digit_d;
      shadow_q   <= shadow_d;
      blank_q    <= blank_d;
      frame_done <= (slot_d == SW'(DIV - 1)) && (digit_d == 2'd3);
      drains     <= lit ? (4'b0001 << digit_d) : 4'b0000;
      leds       <= lit ? hex_font(nib) : 8'h00;
      if (boundary) begin
        state_q <= state_d;
        grant   <= {state_d == SHOW1, state_d == SHOW0};
        if (state_d != state_q || state_q == IDLE)
          dwell_q <= '0;
        else
          dwell_q <= dwell_inc;
        if (state_d != IDLE)
          last_q <= (state_d == SHOW1);
      end
    end
  end

endmodule

// File: doc/seg_scan_arbiter.md
# seg_scan_arbiter

Display controller that shares the 4-digit 8-segment display between two requesters. It arbitrates ownership with a round-robin scheme and a minimum dwell time. It latches the owner's 16-bit value once per frame, so a digit never shows a mix of old and new data. It scans the four digits with an anti-ghosting blank interval and drives the drain and segment pins directly.

## Interface
- DIV, 1024: clocks per digit slot; must be ≥ 4.
- BLANK_CYC, 16: blanked clocks at the start of each slot; must satisfy 1 ≤ BLANK_CYC < DIV.
- DWELL_FRAMES, 64: minimum frames a grant is held before it can be preempted; must be ≥ 1.

Ports:
- clk  in  1  system clock; sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  2  request per requester; level, held while display is wanted.
- data0  in  16  requester 0 value; nibble 0 = digit 0.
- data1  in  16  requester 1 value.
- grant  out  2  one-hot or zero; current owner.
- frame_done  out  1  one-clock pulse on the last clock of each frame.
- drains  out  4  one-hot digit enable; active-high.
- leds  out  8  segments {dp,g,f,e,d,c,b,a}; active-high; dp always 0.

## Operation
- Slot counter runs 0..DIV-1 and digit index runs 0..3. Both run free from reset regardless of grant, so frame boundaries lie on a fixed grid of 4·DIV clocks.
- Frame boundary: the clock where slot = DIV-1 and digit = 3. frame_done is high on that clock.
- State machine, updated only at frame boundaries:
  - IDLE (grant = 0): if any req is set, move to SHOW for the winner. If both are set, the winner is the requester not granted last. The last-granted register resets to 1, so requester 0 wins the first tie.
  - SHOW(i):
    - dwell counter increments per completed frame and saturates at DWELL_FRAMES.
    - If req[i] = 0, go to IDLE, or go directly to SHOW(other) if req[other] = 1.
    - Else, if dwell ≥ DWELL_FRAMES and req[other] = 1, go to SHOW(other).
    - Else stay.
    - Every owner change clears dwell.
- Shadow register: on each boundary, the shadow loads the data of the owner for the next frame. If that next state is IDLE, it loads zero and a blank flag is set.
- Per slot:
  - Clocks 0..BLANK_CYC-1 of the slot: drains = 0 and leds = 0.
  - Remaining clocks: drains = 1<<digit, and leds = hex font of shadow nibble[digit].
  - When the blank flag is set: drains = 0 and leds = 0 for the whole frame.
- Hex font values:
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→6F, A→77, B→7C, C→39, D→5E, E→79, F→71
- Data changes mid-frame have no effect until the next boundary.

## Timing
- rst_n low resets everything immediately:
  - grant = 0, drains = 0, leds = 0, frame_done = 0.
  - slot and digit counters = 0, dwell = 0, shadow = 0, blank flag = 1.
- Reset applied mid-frame aborts the frame. After release, the scan restarts at slot 0, digit 0.
- All outputs are registered.
- grant and shadow update on the clock edge that ends the boundary clock. The first lit drain follows BLANK_CYC clocks later.
- req-to-grant latency, from IDLE: 1 to 4·DIV clocks, depending on the grid position.
- Preemption latency: at least DWELL_FRAMES full frames after the grant.
- A req deassertion mid-frame takes effect at that frame's boundary. The frame in progress completes normally.
- A req pulse shorter than a frame that is low at the boundary is never granted.
- drains is never multi-hot. Between any two distinct lit digits there are at least BLANK_CYC clocks with drains = 0.
- dwell saturates; it never wraps.

## Test plan
All scenarios use DIV=8, BLANK_CYC=2, DWELL_FRAMES=2, one frame = 32 clocks.
- Reset with no req → drains = 0 and leds = 0 for all clocks; frame_done pulses every 32 clocks; grant = 0.
- req=01, data0=0x1234 → grant=01 after the next boundary. Drains sequence per 8-clock slot is 0,0 then six clocks of 0001 with leds=66 ("4"). Then 0010/4F, 0100/5B, 1000/06.
- req=11 raised together from IDLE → grant=01 first, then grant=10 exactly 2 frames later. Ownership then alternates every 2 frames.
- data0 changes 0x0000→0xFFFF mid-frame while granted → the current frame shows only 3F. The next frame shows only 71.
- req[0] drops 5 clocks into a frame while req[1]=1 → grant switches 01→10 at that frame's boundary, with dwell ignored.
- rst_n pulsed low mid-slot while lit → drains, leds and grant are 0 immediately (asynchronous). After release, the scan resumes at digit 0 and the winner is determined as after the initial reset.
